// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-controller signal bundle: stage register info in, stall/flush/forward controls out.
// The pipeline side uses the master modport, the hazard controller the slave modport.
interface hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_regw;
    logic             ex_is_load;
    logic             ex_redirect;
    logic             ex_mdu_start;
    logic             mdu_done;
    logic [4:0]       mem_rd;
    logic             mem_regw;
    logic [4:0]       wb_rd;
    logic             wb_regw;

    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             flush_id;
    logic             flush_ex;
    logic             bubble_mem;
    logic             mdu_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_valid, id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_regw, ex_is_load,
               ex_redirect, ex_mdu_start, mdu_done, mem_rd, mem_regw, wb_rd, wb_regw,
        input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, stall_ex, flush_id, flush_ex,
               bubble_mem, mdu_timeout, stall_cycles, flush_events
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_regw, ex_is_load,
               ex_redirect, ex_mdu_start, mdu_done, mem_rd, mem_regw, wb_rd, wb_regw,
        output fwd_a_sel, fwd_b_sel, stall_if, stall_id, stall_ex, flush_id, flush_ex,
               bubble_mem, mdu_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_controller.sv
// 5-stage pipeline hazard controller: EX operand forwarding, load-use stalls, redirect flushes,
// multi-cycle MDU freeze with a timeout watchdog, and stall/flush performance counters.
module hazard_controller #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input logic               clk,
    input logic               rst_n,
    hazard_controller_if.slave hz
);
    typedef enum logic {RUN, MDU_WAIT} state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(MDU_TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] tmo_cnt, tmo_cnt_nxt;
    logic       tmo_set;
    logic       redirect_evt;
    logic       load_use;

    logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem;
    logic       mdu_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    // MEM result is younger than WB, so it wins; x0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       m_we, input logic [4:0] m_rd,
                                           input logic       w_we, input logic [4:0] w_rd);
        if (m_we && m_rd != 5'd0 && m_rd == rs)
            return 2'b10;
        else if (w_we && w_rd != 5'd0 && w_rd == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign hz.fwd_a_sel = fwd_sel(hz.ex_rs1, hz.mem_regw, hz.mem_rd, hz.wb_regw, hz.wb_rd);
    assign hz.fwd_b_sel = fwd_sel(hz.ex_rs2, hz.mem_regw, hz.mem_rd, hz.wb_regw, hz.wb_rd);

    assign load_use = hz.ex_is_load && hz.ex_regw && (hz.ex_rd != 5'd0) && hz.id_valid &&
                      ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        state_nxt    = state;
        tmo_cnt_nxt  = tmo_cnt;
        tmo_set      = 1'b0;
        redirect_evt = 1'b0;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        bubble_mem   = 1'b0;

        case (state)
            RUN: begin
                if (hz.ex_redirect) begin
                    flush_id     = 1'b1;
                    flush_ex     = 1'b1;
                    redirect_evt = 1'b1;
                end else if (hz.ex_mdu_start) begin
                    stall_if    = 1'b1;
                    stall_id    = 1'b1;
                    stall_ex    = 1'b1;
                    bubble_mem  = 1'b1;
                    tmo_cnt_nxt = 8'd1;
                    state_nxt   = MDU_WAIT;
                end else if (load_use) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
            end
            MDU_WAIT: begin
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                stall_ex   = 1'b1;
                bubble_mem = 1'b1;
                tmo_cnt_nxt = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
                // A done arriving in the same cycle as the limit still counts as a clean finish.
                if (hz.mdu_done) begin
                    state_nxt = RUN;
                end else if (tmo_cnt == TMO_LIMIT) begin
                    state_nxt = RUN;
                    tmo_set   = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            tmo_cnt      <= 8'd0;
            mdu_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            if (tmo_set)
                mdu_timeout <= 1'b1;
            if (stall_if)
                stall_cycles <= stall_cycles + 1'b1;
            if (redirect_evt)
                flush_events <= flush_events + 1'b1;
        end
    end

    assign hz.stall_if     = stall_if;
    assign hz.stall_id     = stall_id;
    assign hz.stall_ex     = stall_ex;
    assign hz.flush_id     = flush_id;
    assign hz.flush_ex     = flush_ex;
    assign hz.bubble_mem   = bubble_mem;
    assign hz.mdu_timeout  = mdu_timeout;
    assign hz.stall_cycles = stall_cycles;
    assign hz.flush_events = flush_events;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller: stimulus pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_controller;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             sif;
        logic             sid;
        logic             sex;
        logic             fid;
        logic             fex;
        logic             bm;
        logic             to;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    hazard_controller_if #(.CNT_W(CNT_W)) hif ();

    hazard_controller #(.MDU_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int step, input logic [CNT_W-1:0] act,
                         input logic [CNT_W-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, expv);
        end
    endtask

    // Monitor: outputs are combinational, so each cycle presents one result at the negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            step_no++;
            check("fwd_a_sel",    step_no, CNT_W'(hif.fwd_a_sel),   CNT_W'(e.fa));
            check("fwd_b_sel",    step_no, CNT_W'(hif.fwd_b_sel),   CNT_W'(e.fb));
            check("stall_if",     step_no, CNT_W'(hif.stall_if),    CNT_W'(e.sif));
            check("stall_id",     step_no, CNT_W'(hif.stall_id),    CNT_W'(e.sid));
            check("stall_ex",     step_no, CNT_W'(hif.stall_ex),    CNT_W'(e.sex));
            check("flush_id",     step_no, CNT_W'(hif.flush_id),    CNT_W'(e.fid));
            check("flush_ex",     step_no, CNT_W'(hif.flush_ex),    CNT_W'(e.fex));
            check("bubble_mem",   step_no, CNT_W'(hif.bubble_mem),  CNT_W'(e.bm));
            check("mdu_timeout",  step_no, CNT_W'(hif.mdu_timeout), CNT_W'(e.to));
            check("stall_cycles", step_no, hif.stall_cycles,        e.sc);
            check("flush_events", step_no, hif.flush_events,        e.fe);
        end
    end

    task automatic idle();
        hif.id_valid     = 1'b0;
        hif.id_rs1       = 5'd0;
        hif.id_rs2       = 5'd0;
        hif.ex_rs1       = 5'd0;
        hif.ex_rs2       = 5'd0;
        hif.ex_rd        = 5'd0;
        hif.ex_regw      = 1'b0;
        hif.ex_is_load   = 1'b0;
        hif.ex_redirect  = 1'b0;
        hif.ex_mdu_start = 1'b0;
        hif.mdu_done     = 1'b0;
        hif.mem_rd       = 5'd0;
        hif.mem_regw     = 1'b0;
        hif.wb_rd        = 5'd0;
        hif.wb_regw      = 1'b0;
    endtask

    // Build an expectation: fa, fb, {sif,sid,sex,fid,fex,bm}, to, sc, fe.
    function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb, input logic [5:0] ctl,
                                input logic to, input int sc, input int fe);
        exp_t e;
        e.fa  = fa;
        e.fb  = fb;
        e.sif = ctl[5];
        e.sid = ctl[4];
        e.sex = ctl[3];
        e.fid = ctl[2];
        e.fex = ctl[1];
        e.bm  = ctl[0];
        e.to  = to;
        e.sc  = CNT_W'(sc);
        e.fe  = CNT_W'(fe);
        return e;
    endfunction

    // Inputs are already applied (just after a posedge); queue the expectation and move one cycle on.
    task automatic cyc(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        idle();
        hif.ex_is_load = 1'b1;
        hif.ex_regw    = 1'b1;
        hif.ex_rd      = rd;
        hif.id_valid   = 1'b1;
        hif.id_rs1     = rs1;
        hif.id_rs2     = rs2;
    endtask

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_LU    = 6'b110010;
    localparam logic [5:0] C_REDIR = 6'b000110;
    localparam logic [5:0] C_MDU   = 6'b111001;

    initial begin
        int bound;
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        // Reset held: combinational outputs behave as in RUN with idle inputs.
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 0, 0));
        rst_n = 1'b1;
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 0, 0));

        // Forwarding priority and x0 suppression.
        hif.ex_rs1 = 5'd7; hif.ex_rs2 = 5'd7;
        hif.mem_rd = 5'd7; hif.mem_regw = 1'b1; hif.wb_rd = 5'd7; hif.wb_regw = 1'b1;
        cyc(mk(2'b10, 2'b10, C_NONE, 1'b0, 0, 0));
        hif.mem_regw = 1'b0;
        cyc(mk(2'b01, 2'b01, C_NONE, 1'b0, 0, 0));
        hif.ex_rs1 = 5'd0; hif.ex_rs2 = 5'd0;
        hif.mem_rd = 5'd0; hif.mem_regw = 1'b1; hif.wb_rd = 5'd0; hif.wb_regw = 1'b1;
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 0, 0));
        hif.ex_rs1 = 5'd3; hif.ex_rs2 = 5'd9;
        hif.mem_rd = 5'd9; hif.mem_regw = 1'b1; hif.wb_rd = 5'd3; hif.wb_regw = 1'b1;
        cyc(mk(2'b01, 2'b10, C_NONE, 1'b0, 0, 0));
        hif.mem_rd = 5'd3; hif.wb_rd = 5'd9; hif.wb_regw = 1'b0;
        cyc(mk(2'b10, 2'b00, C_NONE, 1'b0, 0, 0));

        // Load-use on rs1, then rs2; each is a single bubble cycle.
        load_use(5'd5, 5'd5, 5'd0);
        cyc(mk(2'b00, 2'b00, C_LU, 1'b0, 0, 0));
        idle();
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 1, 0));
        load_use(5'd5, 5'd1, 5'd5);
        cyc(mk(2'b00, 2'b00, C_LU, 1'b0, 1, 0));
        idle();
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 2, 0));
        // No hazard: ID empty, or destination is x0.
        load_use(5'd5, 5'd5, 5'd5);
        hif.id_valid = 1'b0;
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 2, 0));
        load_use(5'd0, 5'd0, 5'd0);
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 2, 0));

        // Redirect masks a simultaneous load-use hazard.
        load_use(5'd5, 5'd5, 5'd0);
        hif.ex_redirect = 1'b1;
        cyc(mk(2'b00, 2'b00, C_REDIR, 1'b0, 2, 0));
        idle();
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 2, 1));

        // MDU: start at cycle 0, done at cycle 4; redirect and load-use ignored while waiting.
        hif.ex_mdu_start = 1'b1;
        cyc(mk(2'b00, 2'b00, C_MDU, 1'b0, 2, 1));
        idle();
        hif.ex_redirect = 1'b1;
        cyc(mk(2'b00, 2'b00, C_MDU, 1'b0, 3, 1));
        load_use(5'd5, 5'd5, 5'd0);
        cyc(mk(2'b00, 2'b00, C_MDU, 1'b0, 4, 1));
        idle();
        cyc(mk(2'b00, 2'b00, C_MDU, 1'b0, 5, 1));
        hif.mdu_done = 1'b1;
        cyc(mk(2'b00, 2'b00, C_MDU, 1'b0, 6, 1));
        idle();
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 7, 1));

        // Done arrives in the same cycle the counter hits the limit: no timeout.
        hif.ex_mdu_start = 1'b1;
        cyc(mk(2'b00, 2'b00, C_MDU, 1'b0, 7, 1));
        idle();
        for (int i = 1; i <= 7; i++)
            cyc(mk(2'b00, 2'b00, C_MDU, 1'b0, 7 + i, 1));
        hif.mdu_done = 1'b1;
        cyc(mk(2'b00, 2'b00, C_MDU, 1'b0, 15, 1));
        idle();
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 16, 1));

        // Timeout: start, never done; flag set after 8 wait cycles and sticks.
        hif.ex_mdu_start = 1'b1;
        cyc(mk(2'b00, 2'b00, C_MDU, 1'b0, 16, 1));
        idle();
        for (int i = 1; i <= 8; i++)
            cyc(mk(2'b00, 2'b00, C_MDU, 1'b0, 16 + i, 1));
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b1, 25, 1));
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b1, 25, 1));

        // Asynchronous reset between clock edges while in MDU_WAIT.
        hif.ex_mdu_start = 1'b1;
        cyc(mk(2'b00, 2'b00, C_MDU, 1'b1, 25, 1));
        idle();
        cyc(mk(2'b00, 2'b00, C_MDU, 1'b1, 26, 1));
        #2;
        rst_n = 1'b0;
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 0, 0));
        rst_n = 1'b1;
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 0, 0));
        hif.ex_redirect = 1'b1;
        cyc(mk(2'b00, 2'b00, C_REDIR, 1'b0, 0, 0));
        idle();
        cyc(mk(2'b00, 2'b00, C_NONE, 1'b0, 0, 1));

        bound = 0;
        while (exp_q.size() > 0 && bound < 20) begin
            @(posedge clk);
            bound++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
